col_accumulator: RTL and testbench

- Downstream of the column convolution engine.
- Consumes its 11-value partial-result vectors (Q8.8), one per kernel column, and sums K of them into one finished output column of the 2D convolution.
- Adds a per-channel bias, applies ReLU with positive saturation, and writes the column into an 11x11 Q8.8 feature-map register array.
- Asserts done when all N_COLS output columns are written; the feature map is the input to the pooling/dense stage.

---
 rtl/cnn_pkg.sv | 32 +++
 rtl/bias_relu_sat.sv | 15 +
 rtl/col_accumulator.sv | 136 +++++++++++++
 tb/tb_col_accumulator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the CNN column datapath.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } acc_state_t;

  // Adds the bias to a lane sum at full precision, then clamps the result to
  // the non-negative Q8.8 range. Any positive value above 0x7FFF saturates
  // instead of wrapping.
  function automatic logic signed [DATA_W-1:0] sat_relu_q88(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [DATA_W-1:0] bias
  );
    logic signed [ACC_W:0] r;
    r = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - DATA_W){bias[DATA_W-1]}}, bias};
    if (r[ACC_W]) begin
      sat_relu_q88 = '0;
    end else if (r[ACC_W-1:DATA_W-1] != '0) begin
      sat_relu_q88 = {1'b0, {(DATA_W - 1){1'b1}}};
    end else begin
      sat_relu_q88 = r[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bias_relu_sat.sv
// One output lane: bias add followed by ReLU with positive saturation.
module bias_relu_sat
  import cnn_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] result
);

  // Purely combinational; the caller registers the lane result.
  always_comb begin
    result = sat_relu_q88(acc, bias);
  end

endmodule

// File: rtl/col_accumulator.sv
// Sums K partial column vectors from the column convolution engine, adds the
// channel bias, applies ReLU/saturation and stores each finished column into
// an N_COLS x OUT_W Q8.8 feature map.
module col_accumulator
  import cnn_pkg::*;
#(
  parameter int OUT_W  = 11,
  parameter int K      = 8,
  parameter int N_COLS = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_values [0:OUT_W-1],
  output logic                     col_valid,
  output logic [3:0]               col_idx,
  output logic signed [DATA_W-1:0] col_out [0:OUT_W-1],
  output logic signed [DATA_W-1:0] fmap [0:N_COLS-1][0:OUT_W-1],
  output logic                     busy,
  output logic                     done
);

  localparam int PART_W = (K > 1) ? $clog2(K) : 1;

  acc_state_t               state;
  logic signed [ACC_W-1:0]  acc [0:OUT_W-1];
  logic signed [DATA_W-1:0] bias;
  logic [PART_W-1:0]        part_cnt;
  logic [3:0]               col_cnt;
  logic signed [DATA_W-1:0] lane_result [0:OUT_W-1];
  logic                     start_ok;
  logic                     accept;
  logic                     last_part;
  logic                     last_col;
  logic                     in_final;

  assign in_ready  = (state == ACCUM);
  assign busy      = (state == ACCUM) || (state == FINAL);
  assign done      = (state == DONE);
  assign in_final  = (state == FINAL);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign accept    = in_valid && in_ready;
  assign last_part = (part_cnt == PART_W'(K - 1));
  assign last_col  = (col_cnt == 4'(N_COLS - 1));

  for (genvar g = 0; g < OUT_W; g++) begin : g_lane
    bias_relu_sat u_lane (
      .acc    (acc[g]),
      .bias   (bias),
      .result (lane_result[g])
    );
  end

  // Control sequence: wait for start, gather K vectors, spend one cycle
  // finishing the column, and park in DONE after the last column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_ok) state <= ACCUM;
        ACCUM:      if (accept && last_part) state <= FINAL;
        FINAL:      state <= last_col ? DONE : ACCUM;
        default:    state <= IDLE;
      endcase
    end
  end

  // Bias latch plus partial-vector and column counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias     <= '0;
      part_cnt <= '0;
      col_cnt  <= '0;
    end else if (start_ok) begin
      bias     <= bias_in;
      part_cnt <= '0;
      col_cnt  <= '0;
    end else if (accept) begin
      part_cnt <= last_part ? '0 : part_cnt + PART_W'(1);
    end else if (in_final) begin
      part_cnt <= '0;
      col_cnt  <= col_cnt + 4'd1;
    end
  end

  // Per-lane running sums; cleared at map start and after each column so
  // nothing carries over into the next column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_W; i++) acc[i] <= '0;
    end else if (start_ok || in_final) begin
      for (int i = 0; i < OUT_W; i++) acc[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < OUT_W; i++) begin
        acc[i] <= acc[i] + {{(ACC_W - DATA_W){in_values[i][DATA_W-1]}}, in_values[i]};
      end
    end
  end

  // Finished-column output: one-cycle valid pulse, data held until the next column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_valid <= 1'b0;
      col_idx   <= '0;
      for (int i = 0; i < OUT_W; i++) col_out[i] <= '0;
    end else begin
      col_valid <= in_final;
      if (in_final) begin
        col_idx <= col_cnt;
        for (int i = 0; i < OUT_W; i++) col_out[i] <= lane_result[i];
      end
    end
  end

  // Feature map storage; wiped when a new map starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_COLS; c++)
        for (int i = 0; i < OUT_W; i++) fmap[c][i] <= '0;
    end else if (start_ok) begin
      for (int c = 0; c < N_COLS; c++)
        for (int i = 0; i < OUT_W; i++) fmap[c][i] <= '0;
    end else if (in_final) begin
      for (int c = 0; c < N_COLS; c++) begin
        if (col_cnt == 4'(c)) begin
          for (int i = 0; i < OUT_W; i++) fmap[c][i] <= lane_result[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_col_accumulator.sv
// Self-checking bench for col_accumulator: randomized traffic compared every
// cycle against a behavioural model, plus literal spot checks.
module tb_col_accumulator;

  localparam int OW = 11;
  localparam int KK = 8;
  localparam int NC = 11;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [15:0]  bias_in;
  logic                in_valid;
  logic                in_ready;
  logic signed [15:0]  in_values [0:OW-1];
  logic                col_valid;
  logic [3:0]          col_idx;
  logic signed [15:0]  col_out [0:OW-1];
  logic signed [15:0]  fmap [0:NC-1][0:OW-1];
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_fail   = 0;
  int cv_count = 0;

  always #5 clk = ~clk;

  col_accumulator #(.OUT_W(OW), .K(KK), .N_COLS(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias_in   (bias_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_values (in_values),
    .col_valid (col_valid),
    .col_idx   (col_idx),
    .col_out   (col_out),
    .fmap      (fmap),
    .busy      (busy),
    .done      (done)
  );

  // One comparison: count it, report it on mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Behavioural model: a map is running after start until N_COLS columns have
  // been produced; each column needs K accepted vectors and then one
  // finishing cycle in which no vector is taken.
  bit m_active, m_final, m_done, m_cv;
  int m_part, m_col, m_bias, m_colidx;
  int m_sum    [0:OW-1];
  int m_colout [0:OW-1];
  int m_fmap   [0:NC-1][0:OW-1];

  function automatic int relu_sat(input int v);
    if (v < 0) return 0;
    if (v > 32767) return 32767;
    return v;
  endfunction

  // Model update on every active edge, or immediately on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_final = 0; m_done = 0; m_cv = 0;
      m_part = 0; m_col = 0; m_bias = 0; m_colidx = 0;
      for (int i = 0; i < OW; i++) begin m_sum[i] = 0; m_colout[i] = 0; end
      for (int c = 0; c < NC; c++) for (int i = 0; i < OW; i++) m_fmap[c][i] = 0;
    end else begin
      m_cv = 0;
      if (m_final) begin
        for (int i = 0; i < OW; i++) begin
          m_colout[i] = relu_sat(m_sum[i] + m_bias);
          m_fmap[m_col][i] = m_colout[i];
          m_sum[i] = 0;
        end
        m_colidx = m_col;
        m_cv = 1;
        m_final = 0;
        m_col++;
        if (m_col == NC) begin m_active = 0; m_done = 1; end
      end else if (m_active) begin
        if (in_valid) begin
          for (int i = 0; i < OW; i++) m_sum[i] += int'(in_values[i]);
          m_part++;
          if (m_part == KK) begin m_part = 0; m_final = 1; end
        end
      end else if (start) begin
        m_active = 1; m_done = 0; m_part = 0; m_col = 0;
        m_bias = int'(bias_in);
        for (int i = 0; i < OW; i++) m_sum[i] = 0;
        for (int c = 0; c < NC; c++) for (int i = 0; i < OW; i++) m_fmap[c][i] = 0;
      end
    end
  end

  int bad_i, bad_c, bad_r;

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (col_valid) cv_count++;
    checkOutput("in_ready", int'(in_ready), int'(m_active && !m_final));
    checkOutput("busy", int'(busy), int'(m_active));
    checkOutput("done", int'(done), int'(m_done));
    checkOutput("col_valid", int'(col_valid), int'(m_cv));
    checkOutput("col_idx", int'(col_idx), m_colidx);
    bad_i = 0;
    for (int i = 0; i < OW; i++)
      if (int'(col_out[i]) != m_colout[i]) begin bad_i = i; break; end
    checkOutput("col_out", int'(col_out[bad_i]), m_colout[bad_i]);
    bad_c = 0; bad_r = 0;
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < OW; i++)
        if (int'(fmap[c][i]) != m_fmap[c][i] && bad_c == 0 && bad_r == 0) begin
          bad_c = c; bad_r = i;
        end
    checkOutput("fmap", int'(fmap[bad_c][bad_r]), m_fmap[bad_c][bad_r]);
  end

  function automatic logic [15:0] rand_val();
    if ($urandom_range(3) == 0) return 16'($urandom);
    return 16'($urandom_range(4095)) - 16'd2048;
  endfunction

  // Runs one map: start with the given bias, offer vectors (constant cval or
  // random), with gap_pct percent idle cycles. abort_at >= 0 stops driving
  // after that many accepted vectors; start_mid pulses start mid-map.
  task automatic applyStimulus(input logic [15:0] bias, input logic [15:0] cval,
                               input bit rnd, input int gap_pct, input int abort_at,
                               input bit start_mid, output int done_edge);
    int edges, accepted;
    bit hs;
    logic signed [15:0] vec [0:OW-1];
    for (int i = 0; i < OW; i++) vec[i] = rnd ? rand_val() : cval;
    @(negedge clk); #1;
    bias_in = bias; start = 1'b1; in_valid = 1'b0;
    edges = 0; accepted = 0; done_edge = -1; hs = 0;
    while (1) begin
      @(negedge clk); edges++;
      #1; start = 1'b0;
      if (done) begin done_edge = edges; break; end
      if (hs) begin
        accepted++;
        for (int i = 0; i < OW; i++) vec[i] = rnd ? rand_val() : cval;
      end
      if (abort_at >= 0 && accepted == abort_at) break;
      if (edges > 3000) begin
        checkOutput("done_within_budget", int'(done), 1);
        break;
      end
      if (start_mid && edges == 20) begin start = 1'b1; bias_in = 16'($urandom); end
      in_valid = (int'($urandom_range(99)) >= gap_pct);
      in_values = vec;
      hs = in_valid && in_ready;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int de, cv0, zero_bad;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; bias_in = '0;
    for (int i = 0; i < OW; i++) in_values[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_fmap", int'(fmap[5][5]), 0);
    rst = 1'b0;

    $display("[TB] unit sum");
    cv0 = cv_count;
    applyStimulus(16'h0000, 16'h0100, 0, 0, -1, 0, de);
    checkOutput("unit_done_edge", de, 100);
    checkOutput("unit_pulses", cv_count - cv0, 11);
    checkOutput("unit_col_out", int'(col_out[5]), 16'h0800);
    checkOutput("unit_fmap", int'(fmap[6][2]), 16'h0800);
    checkOutput("unit_col_idx", int'(col_idx), 10);

    $display("[TB] start in done with bias 0x0100");
    applyStimulus(16'h0100, 16'h0100, 0, 0, -1, 0, de);
    checkOutput("restart_fmap", int'(fmap[0][0]), 16'h0900);

    $display("[TB] relu and bias");
    applyStimulus(16'h0200, 16'hFF00, 0, 0, -1, 0, de);
    checkOutput("relu_neg_fmap", int'(fmap[4][3]), 0);
    applyStimulus(16'hFF80, 16'h0080, 0, 0, -1, 0, de);
    checkOutput("bias_neg_fmap", int'(fmap[9][7]), 16'h0380);

    $display("[TB] saturation");
    applyStimulus(16'h7FFF, 16'h7000, 0, 0, -1, 0, de);
    checkOutput("sat_fmap", int'(fmap[10][10]), 16'h7FFF);

    $display("[TB] backpressure with start during accumulation");
    applyStimulus(16'h0000, 16'h0100, 0, 40, -1, 1, de);
    checkOutput("gap_fmap", int'(fmap[3][8]), 16'h0800);

    $display("[TB] reset mid-map");
    applyStimulus(16'h0000, 16'h0100, 0, 0, 29, 0, de);
    checkOutput("pre_reset_fmap", int'(fmap[2][0]), 16'h0800);
    #1 rst = 1'b1;
    #1;
    zero_bad = 0;
    for (int c = 0; c < NC; c++) for (int i = 0; i < OW; i++) if (fmap[c][i] != 0) zero_bad++;
    for (int i = 0; i < OW; i++) if (col_out[i] != 0) zero_bad++;
    checkOutput("rst_nonzero_values", zero_bad, 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_col_idx", int'(col_idx), 0);
    @(negedge clk); #1 rst = 1'b0;
    applyStimulus(16'h0000, 16'h0100, 0, 0, -1, 0, de);
    checkOutput("post_reset_fmap", int'(fmap[3][5]), 16'h0800);

    $display("[TB] random maps");
    for (int m = 0; m < 4; m++) begin
      applyStimulus(16'($urandom_range(2047)) - 16'd1024, 16'h0000, 1, 30, -1, (m == 1), de);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
